mux2_rr_arbiter: RTL and testbench

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

---
 rtl/mux_arb_pkg.sv | 35 +++
 rtl/mux2_rr_arbiter_rr_arb2.sv | 53 +++++
 rtl/mux2_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// ============================================================================
// Module : mux_arb_pkg
// Brief  : Shared constants and the output-stage state type for mux2_rr_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int   DEFAULT_WIDTH = 8;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

    // Round-robin pick between two requesters; returns the winning source.
    function automatic logic rr_pick(input logic req_a, input logic req_b, input logic last_grant);
        logic pick;
        if (req_a && req_b) begin
            pick = ~last_grant;
        end else if (req_a) begin
            pick = SEL_A;
        end else begin
            pick = SEL_B;
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux2_rr_arbiter_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant with registered last-grant history.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import mux_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic xfer_i,
    output logic grant_a_o,
    output logic grant_b_o,
    output logic grant_src_o,
    output logic last_grant_o
);

    logic last_grant_q;
    logic last_grant_d;
    logic w_pick;

    always_comb begin
        w_pick      = rr_pick(a_req_i, b_req_i, last_grant_q);
        grant_a_o   = a_req_i && (w_pick == SEL_A);
        grant_b_o   = b_req_i && (w_pick == SEL_B);
        grant_src_o = w_pick;
    end

    // History only moves when a grant actually turns into a transfer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer_i) begin
            last_grant_d = w_pick;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= SEL_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant_o = last_grant_q;

endmodule

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// Module : mux2_rr_arbiter
// Brief  : Two-input round-robin arbiter feeding a one-entry registered output
//          stage. Define MUX_ARB_LOCK_EN to hold the grant for whole bursts.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,

    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,

    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             select
);

    stage_state_t     stage_q;
    stage_state_t     stage_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             sel_q;
    logic             sel_d;

    logic             w_req_a;
    logic             w_req_b;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_grant_src;
    logic             w_last_grant;
    logic             w_can_accept;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_in_data;

`ifdef MUX_ARB_LOCK_EN
    logic lock_q;
    logic lock_d;
    logic lock_src_q;
    logic lock_src_d;
    logic w_in_last;

    // A locked source that drops valid stalls arbitration instead of releasing.
    assign w_req_a   = a_valid && (!lock_q || (lock_src_q == SEL_A));
    assign w_req_b   = b_valid && (!lock_q || (lock_src_q == SEL_B));
    assign w_in_last = (w_grant_src == SEL_A) ? a_last : b_last;

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (w_in_xfer) begin
            lock_d     = ~w_in_last;
            lock_src_d = w_grant_src;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_src_q <= SEL_B;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end
`else
    logic w_unused_last;

    assign w_req_a       = a_valid;
    assign w_req_b       = b_valid;
    assign w_unused_last = a_last ^ b_last;
`endif

    rr_arb2 u_rr_arb2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_req_i      (w_req_a),
        .b_req_i      (w_req_b),
        .xfer_i       (w_in_xfer),
        .grant_a_o    (w_grant_a),
        .grant_b_o    (w_grant_b),
        .grant_src_o  (w_grant_src),
        .last_grant_o (w_last_grant)
    );

    // Gating with rst_n keeps both readys low throughout a reset cycle.
    assign w_can_accept = rst_n && ((stage_q == EMPTY) || out_ready);
    assign a_ready      = w_can_accept && w_grant_a;
    assign b_ready      = w_can_accept && w_grant_b;
    assign w_in_xfer    = (a_ready && a_valid) || (b_ready && b_valid);
    assign w_out_xfer   = (stage_q == FULL) && out_ready;
    assign w_in_data    = (w_grant_src == SEL_A) ? a_data : b_data;

    always_comb begin
        stage_d = stage_q;
        data_d  = data_q;
        sel_d   = sel_q;
        case (stage_q)
            EMPTY: begin
                if (w_in_xfer) begin
                    stage_d = FULL;
                end
            end
            FULL: begin
                if (w_out_xfer && !w_in_xfer) begin
                    stage_d = EMPTY;
                end
            end
            default: stage_d = EMPTY;
        endcase
        if (w_in_xfer) begin
            data_d = w_in_data;
            sel_d  = w_grant_src;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= SEL_B;
        end else begin
            stage_q <= stage_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = (stage_q == FULL);
    assign out_data  = data_q;
    assign select    = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
// Module : tb_mux2_rr_arbiter
// Brief  : Scoreboard bench for mux2_rr_arbiter with a rule-level reference
//          model; follows MUX_ARB_LOCK_EN when defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         a_valid = 1'b0;
    logic         b_valid = 1'b0;
    logic         a_last = 1'b0;
    logic         b_last = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a_data = '0;
    logic [W-1:0] b_data = '0;
    logic         a_ready;
    logic         b_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         select;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .select    (select)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         src;
    } beat_t;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];

    // Reference state: stage occupancy, who won last, and the burst lock.
    bit m_full   = 1'b0;
    bit m_last_a = 1'b0;
    bit m_lock   = 1'b0;
    bit m_lock_a = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : model
        bit    can, want_a, want_b, pick_a, pick_b, take_a, take_b;
        beat_t nb;
        if (!rst_n) begin
            check("ready_in_reset", {30'd0, a_ready, b_ready}, 32'd0);
            m_full   = 1'b0;
            m_last_a = 1'b0;
            m_lock   = 1'b0;
            m_lock_a = 1'b0;
            exp_q.delete();
        end else begin
            can    = !m_full || out_ready;
            want_a = a_valid && !(m_lock && !m_lock_a);
            want_b = b_valid && !(m_lock && m_lock_a);
            pick_a = want_a && (!want_b || !m_last_a);
            pick_b = want_b && !pick_a;
            take_a = can && pick_a;
            take_b = can && pick_b;
            check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
            check("a_ready", {31'd0, a_ready}, {31'd0, take_a});
            check("b_ready", {31'd0, b_ready}, {31'd0, take_b});
            if (take_a || take_b) begin
                nb.data = take_a ? a_data : b_data;
                nb.src  = take_a;
                exp_q.push_back(nb);
                m_last_a = take_a;
`ifdef MUX_ARB_LOCK_EN
                m_lock   = take_a ? !a_last : !b_last;
                m_lock_a = take_a;
`endif
                m_full = 1'b1;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst_n && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got data %0h, expected no output", out_data);
            end else begin
                e = exp_q[0];
                check("out_data", {24'd0, out_data}, {24'd0, e.data});
                check("select", {31'd0, select}, {31'd0, e.src});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_last  = 1'b0;
        b_last  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_select", {31'd0, select}, 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_outputs();
    endtask

    initial begin
        int cnt;
        idle();
        rst_n = 1'b0;
        step();
        apply_reset();

        // Single A beat after reset
        out_ready = 1'b1;
        a_valid   = 1'b1;
        a_data    = 8'h3C;
        step();
        idle();
        step();
        step();

        // Continuous tie: strict alternation starting with A
        apply_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h11;
        b_data  = 8'h22;
        repeat (4) step();
        idle();
        step();
        step();

        // Backpressure hold with B waiting
        a_valid   = 1'b1;
        a_data    = 8'h55;
        out_ready = 1'b0;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'h66;
        repeat (3) step();
        out_ready = 1'b1;
        step();
        idle();
        step();
        step();

        // Reset while FULL discards the beat; first tie afterwards goes to A
        a_valid   = 1'b1;
        a_data    = 8'hAA;
        out_ready = 1'b0;
        step();
        idle();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_outputs();
        out_ready = 1'b1;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 8'hA1;
        b_data    = 8'hB1;
        step();
        idle();
        step();
        step();

        // Three-beat A burst against a persistent B requester
        apply_reset();
        out_ready = 1'b1;
        b_valid   = 1'b1;
        b_data    = 8'hB0;
        a_valid   = 1'b1;
        cnt       = 0;
        for (int g = 0; g < 20 && cnt < 3; g++) begin
            a_data = 8'hA0 + 8'(cnt);
            a_last = (cnt == 2);
            @(negedge clk);
            if (a_ready) cnt++;
            @(posedge clk);
            #1;
        end
        check("burst_beats_accepted", cnt, 32'd3);
        a_valid = 1'b0;
        a_last  = 1'b0;
        repeat (3) step();
        idle();
        step();
        step();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            a_valid   = ($urandom_range(0, 3) != 0);
            b_valid   = ($urandom_range(0, 3) != 0);
            a_data    = W'($urandom);
            b_data    = W'($urandom);
            a_last    = ($urandom_range(0, 2) == 0);
            b_last    = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rst_n     = ($urandom_range(0, 63) != 0);
            step();
        end
        rst_n     = 1'b1;
        idle();
        out_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
